// File: rtl/mem_req_arbiter_if.sv
// ============================================================================
//  Module   : mem_req_arbiter_if
//  Purpose  : Requester/memory bus bundle for the two-port memory read arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_req_arbiter_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1
);
  logic [1:0]                           req_i;
  logic [2*ADDRESS_WIDTH-1:0]           addr_i;
  logic [1:0]                           gnt_o;
  logic                                 rsp_valid_o;
  logic                                 rsp_id_o;
  logic [BANKING_FACTOR*DATA_WIDTH-1:0] rsp_data_o;
  logic                                 busy_o;
  logic                                 mem_read_en;
  logic [ADDRESS_WIDTH-1:0]             mem_req_addr;
  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data;

  // Arbiter side
  modport slave (
    input  req_i, addr_i, mem_resp_data,
    output gnt_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o, mem_read_en, mem_req_addr
  );

  // Requesters and memory side
  modport master (
    output req_i, addr_i, mem_resp_data,
    input  gnt_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o, mem_read_en, mem_req_addr
  );
endinterface

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
// ============================================================================
//  Module   : mem_req_arbiter
//  Purpose  : Two-port memory read arbiter, one outstanding request, fixed
//             memory latency. Define ARB_RR_EN for round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int BANKING_FACTOR = 1,
  parameter int MEM_LATENCY    = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  mem_req_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                               r_state;
  state_t                               w_next;
  logic [CNT_W-1:0]                     r_cnt;
  logic [ADDRESS_WIDTH-1:0]             r_addr;
  logic                                 r_id;
  logic                                 r_rsp_valid;
  logic                                 r_rsp_id;
  logic [BANKING_FACTOR*DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]                           w_gnt;
  logic                                 w_win;
  logic                                 w_cnt_done;

`ifdef ARB_RR_EN
  logic r_last;

  // On a tie the port that was not granted last wins
  always_comb begin
    w_win = 1'b0;
    if (bus.req_i == 2'b11) w_win = ~r_last;
    else                    w_win = bus.req_i[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last <= 1'b1;
    else if (|w_gnt) r_last <= w_win;
  end
`else
  always_comb begin
    w_win = ~bus.req_i[0] & bus.req_i[1];
  end
`endif

  assign w_cnt_done = (r_cnt == CNT_W'(MEM_LATENCY - 1));

  always_comb begin
    w_next = r_state;
    w_gnt  = 2'b00;
    case (r_state)
      S_IDLE: begin
        // Grant is held low while reset is asserted so outputs clear at once
        if ((|bus.req_i) && !rst) begin
          w_gnt  = w_win ? 2'b10 : 2'b01;
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_cnt_done) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= (r_state == S_RESP);
      if (|w_gnt) begin
        r_addr <= w_win ? bus.addr_i[ADDRESS_WIDTH +: ADDRESS_WIDTH]
                        : bus.addr_i[0 +: ADDRESS_WIDTH];
        r_id   <= w_win;
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      else if (r_state == S_WAIT && !w_cnt_done) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_RESP) begin
        r_rsp_data <= bus.mem_resp_data;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign bus.gnt_o        = w_gnt;
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_id_o     = r_rsp_id;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.mem_read_en  = (r_state == S_ISSUE);
  assign bus.mem_req_addr = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
//  Module   : tb_mem_req_arbiter
//  Purpose  : Directed self-checking bench; two arbiters (latency 2 and 1)
//             each paired with a fixed-latency memory model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_req_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(16), .BANKING_FACTOR(1)) ifa ();
  mem_req_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(16), .BANKING_FACTOR(1)) ifb ();

  mem_req_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(16), .BANKING_FACTOR(1), .MEM_LATENCY(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mem_req_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(16), .BANKING_FACTOR(1), .MEM_LATENCY(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // 4x4 matrices of 16-bit elements: W at 0x0000, X at 0x1000; element k holds
  // {k%4, k/4} as bytes, plus one for X.
  function automatic logic [15:0] mem_val(input logic [31:0] a);
    int base = (a >= 32'h1000) ? 32'h1000 : 0;
    int idx  = (int'(a) - base) >> 1;
    return 16'(((idx % 4) << 8) | (idx / 4)) + ((base != 0) ? 16'd1 : 16'd0);
  endfunction

  // Memory models: data is valid only in the one cycle the arbiter samples it
  logic [31:0] ma_addr = '0;
  logic [2:0]  ma_pipe = '0;
  logic [31:0] mb_addr = '0;
  logic [1:0]  mb_pipe = '0;

  always_ff @(posedge clk) begin
    ma_pipe <= {ma_pipe[1:0], ifa.mem_read_en};
    if (ifa.mem_read_en) ma_addr <= ifa.mem_req_addr;
    mb_pipe <= {mb_pipe[0], ifb.mem_read_en};
    if (ifb.mem_read_en) mb_addr <= ifb.mem_req_addr;
  end

  assign ifa.mem_resp_data = ma_pipe[2] ? mem_val(ma_addr) : 16'hDEAD;
  assign ifb.mem_resp_data = mb_pipe[1] ? mem_val(mb_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request on dut_a; response expected after edge T+4
  task automatic txn_a(input int port, input logic [31:0] addr, input logic [15:0] exp,
                       input string tag);
    int  k;
    int  rd;
    bit  seen;
    tick;
    ifa.req_i = 2'(2'b01 << port);
    ifa.addr_i[port*32 +: 32] = addr;
    #1;
    chk({tag, "_gnt"}, 32'(ifa.gnt_o), 32'(2'b01 << port));
    tick;
    ifa.req_i = 2'b00;
    chk({tag, "_issue_addr"}, ifa.mem_req_addr, addr);
    rd   = int'(ifa.mem_read_en);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      tick;
      k++;
      rd += int'(ifa.mem_read_en);
      if (ifa.rsp_valid_o) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_rd_cycles"}, 32'(rd), 32'd1);
    chk({tag, "_id"}, 32'(ifa.rsp_id_o), 32'(port));
    chk({tag, "_data"}, 32'(ifa.rsp_data_o), 32'(exp));
    tick;
    chk({tag, "_valid_drop"}, 32'(ifa.rsp_valid_o), 32'd0);
    chk({tag, "_data_hold"}, 32'(ifa.rsp_data_o), 32'(exp));
  endtask

  initial begin
    int gp[$];
    int gc[$];
    int cnt;
    int k;
    bit seen;

    ifa.req_i = 2'b01; ifa.addr_i = '0;
    ifb.req_i = 2'b00; ifb.addr_i = '0;

    // Reset state, with a request pending that must not be granted
    #12;
    chk("rst_gnt", 32'(ifa.gnt_o), 32'd0);
    chk("rst_busy", 32'(ifa.busy_o), 32'd0);
    chk("rst_rd_en", 32'(ifa.mem_read_en), 32'd0);
    chk("rst_addr", ifa.mem_req_addr, 32'd0);
    chk("rst_valid", 32'(ifa.rsp_valid_o), 32'd0);
    chk("rst_data", 32'(ifa.rsp_data_o), 32'd0);
    ifa.req_i = 2'b00;
    #5 rst = 1'b0;

    txn_a(0, 32'h0000_0004, 16'h0200, "p0");
    txn_a(1, 32'h0000_1002, 16'h0101, "p1");

    // Both ports requesting continuously
    tick;
    ifa.req_i  = 2'b11;
    ifa.addr_i = {32'h0000_1002, 32'h0000_0004};
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ifa.gnt_o != 2'b00) begin
        gp.push_back(int'(ifa.gnt_o[1]));
        gc.push_back(c);
        if (gp.size() > 1) chk("tie_gnt_with_rsp", 32'(ifa.rsp_valid_o), 32'd1);
      end
      tick;
    end
    ifa.req_i = 2'b00;
    chk("tie_count", 32'(gp.size()), 32'd4);
    for (int i = 0; i < gp.size() && i < 4; i++) begin
`ifdef ARB_RR_EN
      chk($sformatf("tie_port%0d", i), 32'(gp[i]), 32'(i % 2));
`else
      chk($sformatf("tie_port%0d", i), 32'(gp[i]), 32'd0);
`endif
      if (i > 0) chk($sformatf("tie_gap%0d", i), 32'(gc[i] - gc[i-1]), 32'd5);
    end
    repeat (8) tick;

    // Reset during WAIT drops the in-flight request
    ifa.req_i = 2'b01; ifa.addr_i[31:0] = 32'h0000_0008;
    tick;
    ifa.req_i = 2'b00;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(ifa.busy_o), 32'd0);
    chk("midrst_rd_en", 32'(ifa.mem_read_en), 32'd0);
    chk("midrst_addr", ifa.mem_req_addr, 32'd0);
    chk("midrst_id", 32'(ifa.rsp_id_o), 32'd0);
    chk("midrst_data", 32'(ifa.rsp_data_o), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick;
      cnt += int'(ifa.rsp_valid_o);
    end
    chk("midrst_no_rsp", 32'(cnt), 32'd0);
    txn_a(0, 32'h0000_0008, 16'h0001, "post_rst");

    // Latency-1 arbiter: response after edge T+3
    tick;
    ifb.req_i = 2'b10; ifb.addr_i[63:32] = 32'h0000_0006;
    #1;
    chk("l1_gnt", 32'(ifb.gnt_o), 32'd2);
    tick;
    ifb.req_i = 2'b00;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      tick;
      k++;
      if (ifb.rsp_valid_o) seen = 1'b1;
    end
    chk("l1_latency", 32'(k), 32'd3);
    chk("l1_id", 32'(ifb.rsp_id_o), 32'd1);
    chk("l1_data", 32'(ifb.rsp_data_o), 32'h0300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32: request address width.
REQ-002 Parameter DATA_WIDTH, default 16: element width in bits.
REQ-003 Parameter BANKING_FACTOR, default 1: elements per memory response.
REQ-004 Parameter MEM_LATENCY, default 2, legal >= 1: memory response latency in clock edges after the request is captured.
REQ-005 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req_i  input  2  per-port read request; port 0 = weight loader, port 1 = activation loader.
REQ-008 addr_i  input  2*ADDRESS_WIDTH  per-port byte address; port p uses bits [p*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-009 gnt_o  output  2  per-port one-cycle grant pulse, one-hot or zero.
REQ-010 rsp_valid_o  output  1  one-cycle response strobe.
REQ-011 rsp_id_o  output  1  port that owns the current response.
REQ-012 rsp_data_o  output  BANKING_FACTOR*DATA_WIDTH  response data.
REQ-013 busy_o  output  1  high whenever state != IDLE.
REQ-014 mem_read_en  output  1  memory read strobe.
REQ-015 mem_req_addr  output  ADDRESS_WIDTH  memory request address.
REQ-016 mem_resp_data  input  BANKING_FACTOR*DATA_WIDTH  memory response data; no valid strobe, timing known only through MEM_LATENCY.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; only one memory request SHALL be outstanding at a time.
REQ-018 In IDLE, when any req_i bit is high, the arbiter SHALL pulse gnt_o for the winner (combinational in that cycle), latch its addr_i and port id at the edge, and go to ISSUE.
REQ-019 Requesters SHALL hold req_i and addr_i stable until granted; gnt_o SHALL never be asserted outside IDLE.
REQ-020 In ISSUE, mem_read_en SHALL be 1 for exactly that one cycle and mem_req_addr SHALL equal the latched address; at the next edge the FSM SHALL go to WAIT with the latency counter at 0.
REQ-021 In WAIT, the counter SHALL increment each edge; at the edge where counter == MEM_LATENCY-1, the FSM SHALL go to RESP.
REQ-022 In RESP, mem_resp_data SHALL be registered into rsp_data_o at the closing edge, rsp_id_o SHALL be set to the latched id, rsp_valid_o SHALL be 1 for the following cycle only, and the FSM SHALL return to IDLE.
REQ-023 Latency: for a grant at edge T, rsp_valid_o SHALL be high in the cycle after edge T+MEM_LATENCY+2; back-to-back requests SHALL be spaced at MEM_LATENCY+3 cycles.
REQ-024 rsp_data_o and rsp_id_o SHALL hold their values until the next response; mem_req_addr SHALL hold the last latched address when mem_read_en is 0.
REQ-025 A request arriving in the same cycle as rsp_valid_o (IDLE) SHALL be granted in that cycle.
REQ-026 Fixed priority, used when ARB_RR_EN is undefined: when both ports request, port 0 SHALL win.

Reset
REQ-027 On rst, the FSM SHALL go to IDLE and the counter, latched address, latched id, gnt_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o, mem_read_en and mem_req_addr SHALL all be 0, immediately and asynchronously.
REQ-028 On reset mid-transaction, the in-flight request SHALL be dropped without a response; after release, the first grant SHALL follow normal arbitration.

Configuration
REQ-029 Macro ARB_RR_EN defined: the arbiter SHALL use two-port round-robin with a last-granted pointer (reset value 1, so port 0 wins the first tie); on a tie, the port not last granted SHALL win, and the pointer SHALL update on every grant.
REQ-030 Macro ARB_RR_EN undefined: the arbiter SHALL use the fixed priority of REQ-026 and SHALL contain no pointer.

Verification
REQ-031 Memory model uses N=4, base X 0x1000, MEM_LATENCY=2: a single port-0 request to 0x0004, granted at edge T, SHALL give rsp_valid_o high after edge T+4 with rsp_id_o=0 and rsp_data_o=0x0200.
REQ-032 A port-1 request to 0x1002 SHALL give rsp_id_o=1 and rsp_data_o=0x0101; mem_read_en SHALL be high for exactly 1 cycle.
REQ-033 Both ports requesting continuously, with ARB_RR_EN defined, SHALL produce the grant order 0,1,0,1 with grants 5 cycles apart; with ARB_RR_EN undefined, only port 0 SHALL be granted.
REQ-034 rst asserted during WAIT SHALL make all outputs 0 immediately, with no rsp_valid_o for the dropped request; a new request after release SHALL complete normally.
REQ-035 MEM_LATENCY=1: a grant at T SHALL give rsp_valid_o after edge T+3, with data correct for the address.
